// File: rtl/avg_ram_reader_if.sv
// RAM-side bus of the averaging RAM reader.
//   stored_cnt : number of valid entries written by the averaging writer (0..16)
//   ram_addr   : read address driven to the 16x8 RAM
//   ram_data   : combinational read data of the RAM at ram_addr
// master = reader side, slave = RAM/writer side.
interface avg_ram_reader_if;
    logic [4:0] stored_cnt;
    logic [7:0] ram_data;
    logic [3:0] ram_addr;

    modport master (output ram_addr, input ram_data, input stored_cnt);
    modport slave  (input ram_addr, output ram_data, output stored_cnt);
endinterface

// File: rtl/avg_ram_reader.sv
// Walks the valid entries of the averaging RAM after a button press, holding
// each on the display for HOLD tick pulses, and optionally tracks the maximum.
// Optional feature macro: READER_MAX_EN (max tracker, max_val, DONE shows max).
// Ports:
//   clk, clr   : clock, synchronous active-high reset
//   BTN        : raw start button (asynchronous)
//   tick       : one-clk pacing pulse from the clock divider
//   ram        : RAM bus (stored_cnt, ram_addr, ram_data)
//   disp_val   : value on display          disp_idx : index of displayed entry
//   busy       : pass in progress          done     : pass finished
//   max_val    : largest value read in the current pass
module avg_ram_reader #(
    parameter int unsigned HOLD = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   BTN,
    input  logic                   tick,
    avg_ram_reader_if.master       ram,
    output logic [7:0]             disp_val,
    output logic [3:0]             disp_idx,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             max_val
);
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 5;
    localparam int unsigned HW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [CW-1:0] n_q,        n_d;
    logic [HW-1:0] hold_q,     hold_d;
    logic [DW-1:0] disp_val_q, disp_val_d;
    logic [AW-1:0] disp_idx_q, disp_idx_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          btn_meta_q, btn_meta_d;
    logic          btn_sync_q, btn_sync_d;
    logic          btn_prev_q, btn_prev_d;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic          armed_q,    armed_d;
    logic          start_c;
`ifdef READER_MAX_EN
    logic [DW-1:0] max_q,      max_d;
`endif

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        n_d        = n_q;
        hold_d     = hold_q;
        disp_val_d = disp_val_q;
        disp_idx_d = disp_idx_q;
`ifdef READER_MAX_EN
        max_d      = max_q;
`endif
        btn_meta_d = BTN;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
        // sync_vld marks when btn_sync_q carries a real sample again after clr;
        // the button must be seen released before a rising edge counts.
        sync_vld_d = {sync_vld_q[0], 1'b1};
        armed_d    = armed_q | (sync_vld_q[1] & ~btn_sync_q);
        start_c    = armed_q & btn_sync_q & ~btn_prev_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_c) begin
                    n_d    = (ram.stored_cnt > CW'(16)) ? CW'(16) : ram.stored_cnt;
                    addr_d = '0;
                    hold_d = '0;
`ifdef READER_MAX_EN
                    max_d  = '0;
`endif
                    if (ram.stored_cnt == '0) begin
                        state_d    = ST_DONE;
                        disp_val_d = '0;
                        disp_idx_d = '0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                disp_val_d = ram.ram_data;
                disp_idx_d = addr_q;
`ifdef READER_MAX_EN
                max_d      = (ram.ram_data > max_q) ? ram.ram_data : max_q;
`endif
                hold_d     = '0;
                state_d    = ST_SHOW;
            end
            ST_SHOW: begin
                if (tick) begin
                    if (hold_q == HW'(HOLD - 1)) begin
                        hold_d = '0;
                        if ({1'b0, addr_q} == n_q - CW'(1)) begin
                            state_d = ST_DONE;
`ifdef READER_MAX_EN
                            disp_val_d = max_q;
`endif
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHOW);
        done_d = (state_d == ST_DONE);
    end

    // State registers; clr overrides everything
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            n_q        <= '0;
            hold_q     <= '0;
            disp_val_q <= '0;
            disp_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            sync_vld_q <= '0;
            armed_q    <= 1'b0;
`ifdef READER_MAX_EN
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
            hold_q     <= hold_d;
            disp_val_q <= disp_val_d;
            disp_idx_q <= disp_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
            sync_vld_q <= sync_vld_d;
            armed_q    <= armed_d;
`ifdef READER_MAX_EN
            max_q      <= max_d;
`endif
        end
    end

    assign ram.ram_addr = addr_q;
    assign disp_val     = disp_val_q;
    assign disp_idx     = disp_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef READER_MAX_EN
    assign max_val      = max_q;
`else
    assign max_val      = '0;
`endif
endmodule

// File: tb/tb_avg_ram_reader.sv
// Bench for avg_ram_reader: table of display passes plus hand-written
// mid-pass start and clr sequences; displayed entries checked via a scoreboard.
module tb_avg_ram_reader;
    localparam int unsigned HOLD = 4;

    logic       clk;
    logic       clr;
    logic       BTN;
    logic       tick;
    logic [7:0] disp_val;
    logic [3:0] disp_idx;
    logic       busy;
    logic       done;
    logic [7:0] max_val;
    logic [7:0] mem [16];
    logic [4:0] stored_cnt_drv;
    bit         tick_mode;

    avg_ram_reader_if bus ();
    assign bus.stored_cnt = stored_cnt_drv;
    assign bus.ram_data   = mem[bus.ram_addr];

    avg_ram_reader #(.HOLD(HOLD)) dut (
        .clk      (clk),
        .clr      (clr),
        .BTN      (BTN),
        .tick     (tick),
        .ram      (bus),
        .disp_val (disp_val),
        .disp_idx (disp_idx),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val)
    );

    typedef struct {
        logic [7:0] val;
        logic [3:0] idx;
    } entry_t;

    typedef struct {
        logic [4:0] cnt;
        int         mode;
        int         exp_n;
        logic [7:0] exp_max;
        bit         mid_press;
        bit         rand_tick;
    } vec_t;

    entry_t sb_q[$];
    int     checks = 0;
    int     errors = 0;
    int     pass_id = 0;

    // monitor-owned pass statistics
    int     seen_pass = 0;
    int     max_addr = 0;
    bit     wrapped = 0;
    bit     busy_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_ram(input int mode);
        logic [7:0] base [3];
        base[0] = 8'h10; base[1] = 8'h20; base[2] = 8'h18;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       mem[i] = (i < 3) ? base[i] : 8'h05;
                1:       mem[i] = 8'(i + 16);
                default: mem[i] = 8'(240 - 8 * i);
            endcase
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = tick_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: detects each newly displayed entry, pops the scoreboard and
    // counts the ticks each entry was held (tick in the LOAD cycle excluded).
    initial begin
        logic [7:0] prev_val;
        logic [3:0] prev_idx;
        logic       prev_busy;
        int         prev_addr;
        int         tick_cnt;
        int         last_tick;
        bit         first;
        bit         ev;
        entry_t     e;
        prev_val = '0; prev_idx = '0; prev_busy = 1'b0; prev_addr = 0;
        tick_cnt = 0; last_tick = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            if (seen_pass != pass_id) begin
                seen_pass = pass_id;
                first = 1'b1; tick_cnt = 0; last_tick = 0;
                max_addr = 0; wrapped = 1'b0; busy_seen = 1'b0; prev_addr = 0;
            end
            if (clr) begin
                sb_q.delete();
                first = 1'b1; tick_cnt = 0; last_tick = 0;
            end else begin
                ev = busy && (disp_val != prev_val || disp_idx != prev_idx);
                if (ev) begin
                    if (!first) chk("hold_ticks", 32'(tick_cnt), 32'(HOLD));
                    first = 1'b0;
                    tick_cnt = 0;
                    chk("entry_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("entry_val", 32'(disp_val), 32'(e.val));
                        chk("entry_idx", 32'(disp_idx), 32'(e.idx));
                    end
                end else begin
                    tick_cnt += last_tick;
                    if (prev_busy && !busy && done)
                        chk("last_hold_ticks", 32'(tick_cnt), 32'(HOLD));
                end
                last_tick = (busy && tick) ? 1 : 0;
            end
            if (busy) begin
                busy_seen = 1'b1;
                if (int'(bus.ram_addr) > max_addr) max_addr = int'(bus.ram_addr);
                if (prev_busy && int'(bus.ram_addr) < prev_addr) wrapped = 1'b1;
                prev_addr = int'(bus.ram_addr);
            end
            prev_busy = busy;
            prev_val  = disp_val;
            prev_idx  = disp_idx;
        end
    end

    task automatic press_btn();
        @(posedge clk);
        #1;
        BTN = 1'b1;
    endtask

    task automatic run_pass(input vec_t v);
        logic [7:0] exp_done_val;
        entry_t     e;
        stored_cnt_drv = v.cnt;
        tick_mode = v.rand_tick;
        for (int i = 0; i < v.exp_n; i++) begin
            e.val = mem[i];
            e.idx = 4'(i);
            sb_q.push_back(e);
        end
        pass_id++;
        press_btn();
        // start event falls after the 2nd edge; state changes on the 3rd
        repeat (3) @(posedge clk);
        #1;
        BTN = 1'b0;
        stored_cnt_drv = 5'd7;
        chk("start_max_clr", 32'(max_val), 32'd0);
        chk("start_busy", 32'(busy), 32'(v.exp_n > 0));
        chk("start_done", 32'(done), 32'(v.exp_n == 0));
        if (v.exp_n > 0) begin
            @(posedge clk);
            #1;
            chk("first_latency_val", 32'(disp_val), 32'(mem[0]));
            chk("first_latency_idx", 32'(disp_idx), 32'd0);
        end
        if (v.mid_press) begin
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (busy && disp_idx == 4'd1) break;
            end
            chk("reach_idx1", 32'(disp_idx), 32'd1);
            BTN = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            BTN = 1'b0;
        end
        for (int k = 0; k < 3000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_reached", 32'(done), 32'd1);
`ifdef READER_MAX_EN
        exp_done_val = v.exp_max;
        chk("done_max", 32'(max_val), 32'(v.exp_max));
`else
        exp_done_val = (v.exp_n == 0) ? 8'h00 : mem[v.exp_n - 1];
        chk("done_max", 32'(max_val), 32'd0);
`endif
        chk("done_disp_val", 32'(disp_val), 32'(exp_done_val));
        chk("done_disp_idx", 32'(disp_idx), (v.exp_n == 0) ? 32'd0 : 32'(v.exp_n - 1));
        chk("done_busy", 32'(busy), 32'd0);
        chk("busy_seen", 32'(busy_seen), 32'(v.exp_n > 0));
        if (v.exp_n > 0) begin
            chk("max_addr", 32'(max_addr), 32'(v.exp_n - 1));
            chk("no_wrap", 32'(wrapped), 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("done_held", 32'(done), 32'd1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},     32'(bus.ram_addr), 32'd0);
        chk({tag, "_disp_val"}, 32'(disp_val),     32'd0);
        chk({tag, "_disp_idx"}, 32'(disp_idx),     32'd0);
        chk({tag, "_max"},      32'(max_val),      32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_done"},     32'(done),         32'd0);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t v;
        vecs[0] = '{cnt: 5'd3,  mode: 0, exp_n: 3,  exp_max: 8'h20, mid_press: 1'b0, rand_tick: 1'b0};
        vecs[1] = '{cnt: 5'd0,  mode: 0, exp_n: 0,  exp_max: 8'h00, mid_press: 1'b0, rand_tick: 1'b1};
        vecs[2] = '{cnt: 5'd20, mode: 1, exp_n: 16, exp_max: 8'h1F, mid_press: 1'b0, rand_tick: 1'b1};
        vecs[3] = '{cnt: 5'd3,  mode: 0, exp_n: 3,  exp_max: 8'h20, mid_press: 1'b1, rand_tick: 1'b1};
        vecs[4] = '{cnt: 5'd1,  mode: 0, exp_n: 1,  exp_max: 8'h10, mid_press: 1'b0, rand_tick: 1'b0};
        vecs[5] = '{cnt: 5'd5,  mode: 2, exp_n: 5,  exp_max: 8'hF0, mid_press: 1'b0, rand_tick: 1'b1};
        vecs[6] = '{cnt: 5'd16, mode: 2, exp_n: 16, exp_max: 8'hF0, mid_press: 1'b0, rand_tick: 1'b0};

        clr = 1'b1;
        BTN = 1'b0;
        tick_mode = 1'b0;
        stored_cnt_drv = '0;
        fill_ram(0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        clr = 1'b0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            fill_ram(vecs[i].mode);
            run_pass(vecs[i]);
        end

        // clr in the middle of entry 2 with the button held through release
        fill_ram(0);
        stored_cnt_drv = 5'd3;
        tick_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            entry_t e;
            e.val = mem[i];
            e.idx = 4'(i);
            sb_q.push_back(e);
        end
        pass_id++;
        press_btn();
        repeat (3) @(posedge clk);
        #1;
        BTN = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (busy && disp_idx == 4'd2) break;
        end
        chk("reach_idx2", 32'(disp_idx), 32'd2);
        BTN = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midclr");
        clr = 1'b0;
        pass_id++;
        repeat (20) @(posedge clk);
        #1;
        chk("held_btn_no_pass", 32'(busy_seen), 32'd0);
        chk("held_btn_done", 32'(done), 32'd0);
        BTN = 1'b0;
        repeat (4) @(posedge clk);
        v = vecs[0];
        v.rand_tick = 1'b1;
        run_pass(v);

        // clr in the same cycle as a start event
        pass_id++;
        press_btn();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("clr_start");
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("clr_start_no_pass", 32'(busy_seen), 32'd0);
        BTN = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/avg_ram_reader.md
AVG_RAM_READER -- requirements
Module: avg_ram_reader

Interface
REQ-001 Parameter HOLD, default 4: number of `tick` pulses each RAM entry stays on display; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 BTN  input  1  raw start button, asynchronous to clk.
REQ-005 tick  input  1  one-clk-wide enable pulse from the clock divider; paces display stepping.
REQ-006 stored_cnt  input  5  number of valid RAM entries written by the averaging writer, 0..16.
REQ-007 ram_data  input  8  combinational read data of the 16x8 single-port RAM at ram_addr.
REQ-008 ram_addr  output  4  read address driven to the RAM (RAM we held 0 by the top level).
REQ-009 disp_val  output  8  value currently displayed (feeds univ_sseg cnt1).
REQ-010 disp_idx  output  4  index of the displayed entry (feeds univ_sseg cnt2).
REQ-011 busy  output  1  high in LOAD and SHOW.
REQ-012 done  output  1  high in DONE.
REQ-013 max_val  output  8  largest value read in the current pass.

Function
REQ-014 BTN shall pass through a 2-flop synchronizer; a start event is a 0->1 transition of the synchronized signal, one clk wide.
REQ-015 States shall be IDLE, LOAD, SHOW, DONE.
REQ-016 On a start in IDLE or DONE: latch N = min(stored_cnt,16), clear max_val, set ram_addr=0; N==0 -> DONE, else -> LOAD.
REQ-017 LOAD lasts exactly one clk: disp_val<=ram_data, disp_idx<=ram_addr, max_val<=max(max_val,ram_data), hold counter<=0, -> SHOW.
REQ-018 SHOW: each tick increments the hold counter; on the tick where the counter equals HOLD-1: if ram_addr==N-1 -> DONE, else ram_addr+1 -> LOAD.
REQ-019 Start events in LOAD or SHOW shall be ignored; stored_cnt changes after the latch shall not affect the pass.
REQ-020 ram_addr shall never exceed N-1 during a pass and shall not wrap.
REQ-021 tick asserted in the LOAD cycle shall not be counted.
REQ-022 In DONE, disp_val shall show max_val (with REQ-027 enabled) and disp_idx shall hold N-1 (0 when N==0); done stays high until the next start or clr.
REQ-023 Display latency: the first entry appears on disp_val 2 clk after the start event (transition into LOAD, then the LOAD capture).

Reset
REQ-024 clr shall force IDLE, ram_addr=0, disp_val=0, disp_idx=0, max_val=0, busy=0, done=0, hold counter=0, latched N=0, and synchronizer flops=0.
REQ-025 clr shall have priority over all other inputs, including when asserted mid-pass or in the same cycle as a start event.
REQ-026 A BTN held high through clr release shall not produce a start event until it is released and pressed again.

Configuration
REQ-027 Macro READER_MAX_EN: when defined, the max tracker, max_val, and DONE display of max_val (REQ-022) are compiled in; when undefined, max_val is tied to 0 and DONE keeps the last captured entry on disp_val.

Verification
REQ-028 RAM={0x10,0x20,0x18}, stored_cnt=3, HOLD=4, start -> disp_val sequence 0x10,0x20,0x18, each held 4 ticks; done=1; max_val=0x20; disp_val=0x20 in DONE.
REQ-029 stored_cnt=0, start -> DONE on the next clk, busy never high, max_val=0, disp_idx=0.
REQ-030 stored_cnt=20 with RAM[i]=i+0x10 -> exactly 16 entries shown, last is 0x1F at disp_idx=15, ram_addr never wraps to 0.
REQ-031 Second start during SHOW of entry 1 -> ignored, sequence completes unchanged; start in DONE -> new pass from addr 0 with max_val cleared.
REQ-032 clr asserted during SHOW of entry 2 -> next clk all outputs 0, state IDLE; BTN held through release -> no pass starts.
REQ-033 Build without READER_MAX_EN, REQ-028 stimulus -> max_val=0 throughout, disp_val=0x18 in DONE.
